ceil_div_seq: RTL and testbench

Run-time sequential counterpart of the elaboration-time `ceil_div` constant function. It computes ceil(dividend / divisor) for unsigned operands whose values are only known at run time. It sits behind a valid/ready request port and in front of a valid/ready result port. Its sizing uses the `CfMath` package, for example `CfMath::log2` for the iteration counter. It is used by address-generation and burst-splitting logic that need beat or page counts from run-time lengths.

---
 rtl/ceil_div_seq_pkg.sv | 33 +++
 rtl/ceil_div_step.sv | 29 ++
 rtl/ceil_div_seq.sv | 148 ++++++++++++++
 tb/tb_ceil_div_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ceil_div_seq_pkg.sv
// CfMath: elaboration-time math helpers used to size run-time datapaths.
// ceil_div_seq_pkg: shared types for the ceil_div_seq sequential divider.
//   state_e - FSM state encoding (IDLE, CALC, ADJ, DONE).

package CfMath;

    // Ceiling log2, floored at 1 so a counter sized with it always has a bit.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

package ceil_div_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/ceil_div_step.sv
// One restoring radix-2 division step (purely combinational).
// Ports:
//   i_rem     - current partial remainder (always < divisor, so W bits suffice)
//   i_bit     - next dividend bit, MSB first
//   i_divisor - divisor
//   o_rem     - next partial remainder, W+1 bits wide
//   o_q_bit   - quotient bit produced by this step

module ceil_div_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rem,
    input  logic                  i_bit,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic [DATA_WIDTH:0]   o_rem,
    output logic                  o_q_bit
);

    logic [DATA_WIDTH:0] w_shifted;
    logic [DATA_WIDTH:0] w_diff;

    always_comb begin
        w_shifted = {i_rem, i_bit};
        w_diff    = w_shifted - {1'b0, i_divisor};
        o_q_bit   = (w_shifted >= {1'b0, i_divisor});
        o_rem     = o_q_bit ? w_diff : w_shifted;
    end

endmodule

// File: rtl/ceil_div_seq.sv
// Sequential ceiling divider: quotient = ceil(dividend / divisor) for run-time
// unsigned operands, one restoring step per cycle, behind valid/ready ports.
// Ports:
//   clk_i, rst_i              - clock, asynchronous active-high reset
//   in_valid_i / in_ready_o   - request handshake (ready only in IDLE)
//   dividend_i, divisor_i     - operands, sampled on the request handshake
//   out_valid_o / out_ready_i - result handshake (valid only in DONE)
//   quotient_o                - ceil(dividend / divisor), all ones on divide by zero
//   remainder_o               - dividend mod divisor, dividend on divide by zero
//   exact_o                   - remainder is zero (never set on divide by zero)
//   div_zero_o                - divisor was zero

module ceil_div_seq
    import ceil_div_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  exact_o,
    output logic                  div_zero_o
);

    localparam int unsigned CntWidth = CfMath::log2(DATA_WIDTH);
    localparam logic [CntWidth-1:0] CntStart = CntWidth'(DATA_WIDTH - 1);

    state_e                r_state,   w_state_nxt;
    // Holds the dividend at accept and shifts quotient bits in from the LSB,
    // so after the last step it contains the floor quotient.
    logic [DATA_WIDTH-1:0] r_quot,    w_quot_nxt;
    logic [DATA_WIDTH:0]   r_rem,     w_rem_nxt;
    logic [DATA_WIDTH-1:0] r_divisor, w_divisor_nxt;
    logic [CntWidth-1:0]   r_cnt,     w_cnt_nxt;
    logic                  r_exact,   w_exact_nxt;
    logic                  r_dz,      w_dz_nxt;

    logic [DATA_WIDTH:0]   w_step_rem;
    logic                  w_step_q;

    // The partial remainder is always below the divisor entering a step, so
    // its top bit is zero and only the low W bits feed the shift.
    ceil_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .i_rem     (r_rem[DATA_WIDTH-1:0]),
        .i_bit     (r_quot[DATA_WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_step_q)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_quot_nxt    = r_quot;
        w_rem_nxt     = r_rem;
        w_divisor_nxt = r_divisor;
        w_cnt_nxt     = r_cnt;
        w_exact_nxt   = r_exact;
        w_dz_nxt      = r_dz;

        unique case (r_state)
            IDLE: begin
                if (in_valid_i) begin
                    w_divisor_nxt = divisor_i;
                    w_cnt_nxt     = CntStart;
                    w_exact_nxt   = 1'b0;
                    if (divisor_i == '0) begin
                        // Divide by zero bypasses the datapath entirely.
                        w_quot_nxt  = '1;
                        w_rem_nxt   = {1'b0, dividend_i};
                        w_dz_nxt    = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_quot_nxt  = dividend_i;
                        w_rem_nxt   = '0;
                        w_dz_nxt    = 1'b0;
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                w_quot_nxt = {r_quot[DATA_WIDTH-2:0], w_step_q};
                w_rem_nxt  = w_step_rem;
                if (r_cnt == '0) begin
                    w_state_nxt = ADJ;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ADJ: begin
                // Non-zero remainder implies divisor >= 2, so the +1 cannot wrap.
                if (r_rem != '0) begin
                    w_quot_nxt  = r_quot + 1'b1;
                    w_exact_nxt = 1'b0;
                end else begin
                    w_exact_nxt = 1'b1;
                end
                w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_exact   <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_quot    <= w_quot_nxt;
            r_rem     <= w_rem_nxt;
            r_divisor <= w_divisor_nxt;
            r_cnt     <= w_cnt_nxt;
            r_exact   <= w_exact_nxt;
            r_dz      <= w_dz_nxt;
        end
    end

    always_comb begin
        in_ready_o  = (r_state == IDLE);
        out_valid_o = (r_state == DONE);
        quotient_o  = r_quot;
        remainder_o = r_rem[DATA_WIDTH-1:0];
        exact_o     = r_exact;
        div_zero_o  = r_dz;
    end

endmodule

// File: tb/tb_ceil_div_seq.sv
// Self-checking bench for ceil_div_seq at DATA_WIDTH = 8: directed scenarios
// plus randomized operands against a plain-arithmetic reference model.

module tb_ceil_div_seq;

    localparam int unsigned W = 8;
    localparam int unsigned NumRandom = 3000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         exact;
    logic         div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ceil_div_seq #(
        .DATA_WIDTH (W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .exact_o     (exact),
        .div_zero_o  (div_zero)
    );

    // Reference: ceil division computed with ordinary integer arithmetic.
    function automatic void ref_div(input int unsigned a, input int unsigned b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic ex, output logic dz);
        if (b == 0) begin
            q  = '1;
            r  = W'(a);
            ex = 1'b0;
            dz = 1'b1;
        end else begin
            q  = W'((a + b - 1) / b);
            r  = W'(a % b);
            ex = ((a % b) == 0);
            dz = 1'b0;
        end
    endfunction

    // Present one request and return at the negedge after its accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL start_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Returns the cycle number (accept cycle = 0) at which out_valid is first seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_tests++;
        if ({in_ready, out_valid, quotient, remainder, exact, div_zero} !==
            {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%0b vld=%0b q=%0d r=%0d ex=%0b dz=%0b, required 1 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, exact, div_zero);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int unsigned ta [5] = '{7, 8, 0, 255, 255};
        int unsigned tb [5] = '{2, 2, 5, 1, 254};
        logic [W-1:0] eq, er;
        logic eex, edz;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ref_div(ta[i], tb[i], eq, er, eex, edz);
            start_op(W'(ta[i]), W'(tb[i]));
            wait_valid(lat);
            n_tests++;
            if (lat !== W + 2) begin
                n_fail++;
                $display("FAIL basic_latency %0d/%0d: cycle %0d, required %0d", ta[i], tb[i], lat, W + 2);
            end
            n_tests++;
            if ({quotient, remainder, exact, div_zero} !== {eq, er, eex, edz}) begin
                n_fail++;
                $display("FAIL basic_result %0d/%0d: q=%0d r=%0d ex=%0b dz=%0b, required q=%0d r=%0d ex=%0b dz=%0b",
                         ta[i], tb[i], quotient, remainder, exact, div_zero, eq, er, eex, edz);
            end
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_return_idle %0d/%0d: rdy=%0b vld=%0b, required 1 0",
                         ta[i], tb[i], in_ready, out_valid);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        out_ready = 1'b1;
        start_op(8'd5, 8'd0);
        wait_valid(lat);
        n_tests++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL divzero_latency: cycle %0d, required 1", lat);
        end
        n_tests++;
        if ({quotient, remainder, exact, div_zero, in_ready} !== {8'hFF, 8'd5, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL divzero_result: q=%0h r=%0d ex=%0b dz=%0b rdy=%0b, required q=ff r=5 ex=0 dz=1 rdy=0",
                     quotient, remainder, exact, div_zero, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        int lat;
        int bad;
        out_ready = 1'b0;
        start_op(8'd13, 8'd4);
        wait_valid(lat);
        n_tests++;
        if (!out_valid || quotient !== 8'd4 || remainder !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_first: vld=%0b q=%0d r=%0d, required 1 4 1", out_valid, quotient, remainder);
        end
        // A competing request is held pending for the whole stall.
        in_valid = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd7;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!out_valid || in_ready || quotient !== 8'd4 || remainder !== 8'd1) begin
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d bad cycles (last vld=%0b rdy=%0b q=%0d r=%0d), required 0",
                     bad, out_valid, in_ready, quotient, remainder);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%0b vld=%0b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        out_ready = 1'b1;
        start_op(8'd200, 8'd3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, out_valid, quotient, remainder, exact, div_zero} !==
            {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_state: rdy=%0b vld=%0b q=%0d r=%0d ex=%0b dz=%0b, required 1 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, exact, div_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midreset_discard: out_valid high %0d cycles, required 0", seen);
        end
        start_op(8'd9, 8'd3);
        wait_valid(lat);
        n_tests++;
        if (lat !== W + 2 || {quotient, remainder, exact, div_zero} !== {8'd3, 8'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_next: cycle=%0d q=%0d r=%0d ex=%0b dz=%0b, required cycle=%0d q=3 r=0 ex=1 dz=0",
                     lat, quotient, remainder, exact, div_zero, W + 2);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        logic eex, edz, rdy;
        int lat, sel, bad, exp_lat;
        for (int i = 0; i < NumRandom; i++) begin
            a   = W'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = '0;
            else if (sel == 1) b = 8'd1;
            else if (sel <= 4) b = W'($urandom_range(1, 15));
            else               b = W'($urandom);
            ref_div(int'(a), int'(b), eq, er, eex, edz);
            exp_lat = (b == 0) ? 1 : W + 2;
            out_ready = 1'($urandom_range(0, 1));
            start_op(a, b);
            wait_valid(lat);
            n_tests++;
            if (lat !== exp_lat || {quotient, remainder, exact, div_zero} !== {eq, er, eex, edz}) begin
                n_fail++;
                $display("FAIL random_result %0d/%0d: cycle=%0d q=%0d r=%0d ex=%0b dz=%0b, required cycle=%0d q=%0d r=%0d ex=%0b dz=%0b",
                         a, b, lat, quotient, remainder, exact, div_zero, exp_lat, eq, er, eex, edz);
            end
            bad = 0;
            for (int k = 0; k < 64; k++) begin
                if (k == 63) out_ready = 1'b1;
                rdy = out_ready;
                @(negedge clk);
                if (rdy) break;
                if (!out_valid || {quotient, remainder, exact, div_zero} !== {eq, er, eex, edz}) bad++;
                out_ready = 1'($urandom_range(0, 1));
            end
            if (in_ready !== 1'b1 || out_valid !== 1'b0) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL random_hold %0d/%0d: %0d bad cycles (rdy=%0b vld=%0b), required 0",
                         a, b, bad, in_ready, out_valid);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
